tank_hit_ctrl: RTL and testbench
================================

// Module: tank_hit_ctrl
// PURPOSE
//  Downstream of the two per-player tank movers. Each frame, checks each live bullet
//  against the opposing tank's bounding box, decrements health, and applies hit cooldown.
//  Runs the round state machine (IDLE/PLAY/OVER) and reports the winner.
//  Pulses bullet_kill back to the movers so they clear the bullet.
// PARAMETERS
//  TANK_SIZE       32   tank box edge, pixels
//  BULLET_SIZE     16   bullet box edge, pixels
//  MAX_HEALTH      3    health loaded on entry to PLAY (fits HEALTH_W)
//  HEALTH_W        2    health counter width
//  COOLDOWN_FRAMES 30   frames a tank is immune after being hit (fits 6 bits)
// PORTS
//  Clk            in   1   system clock, 50 MHz
//  Reset          in   1   synchronous, active-high
//  frame_clk      in   1   ~60 Hz frame strobe (async level, sampled on Clk)
//  start          in   1   round start/acknowledge (level, edge-detected internally)
//  t1_X, t1_Y     in   10  player-1 tank top-left
//  t2_X, t2_Y     in   10  player-2 tank top-left
//  b1_X, b1_Y     in   10  player-1 bullet top-left
//  b2_X, b2_Y     in   10  player-2 bullet top-left
//  b1_live        in   1   player-1 bullet on screen (mover hit==2'b01)
//  b2_live        in   1   player-2 bullet on screen
//  p1_health      out  HEALTH_W  player-1 health
//  p2_health      out  HEALTH_W  player-2 health
//  b1_kill        out  1   1-cycle pulse: bullet 1 struck tank 2, clear it
//  b2_kill        out  1   1-cycle pulse: bullet 2 struck tank 1, clear it
//  t1_flash       out  1   tank-1 blink enable while immune
//  t2_flash       out  1   tank-2 blink enable while immune
//  game_state     out  2   00 IDLE, 01 PLAY, 10 OVER
//  winner         out  2   00 none, 01 P1, 10 P2, 11 draw
// BEHAVIOUR
//  Reset (sync, dominates all): state IDLE, healths=MAX_HEALTH, cooldowns=0, winner=00,
//   kills=0, flashes=0, edge-detect history=0; a tick coinciding with Reset is dropped.
//  frame_tick: registered; high 1 Clk cycle, the cycle after frame_clk sampled 1 with prior 0.
//  start_pulse: rising edge of start, same registered scheme as frame_tick.
//  FSM: IDLE --start_pulse--> PLAY (healths<=MAX, cooldowns<=0, winner<=00).
//       PLAY --any health reaches 0--> OVER (same update edge as the decrement).
//       OVER --start_pulse--> IDLE (winner held until then). start ignored in PLAY.
//  Overlap(b,t): 11-bit unsigned compare, no wrap:
//   bX < tX+TANK_SIZE && bX+BULLET_SIZE > tX && bY < tY+TANK_SIZE && bY+BULLET_SIZE > tY.
//  On frame_tick in PLAY only:
//   hit2 = b1_live && Overlap(b1,t2) && cd2==0 ; hit1 = b2_live && Overlap(b2,t1) && cd1==0.
//   hit2: p2_health-1 (saturate at 0), cd2<=COOLDOWN_FRAMES, b1_kill=1 next cycle. hit1 mirrors.
//   Overlap while immune: no damage, no kill pulse (bullet passes through).
//   Cooldowns not loaded this tick decrement by 1 toward 0.
//   Both hits same tick: both applied; both reach 0 -> winner=11 (draw).
//   Only p2 reaches 0 -> winner=01; only p1 -> winner=10.
//   Own bullet over own tank: ignored.
//  Latency: outputs update on the Clk edge ending the frame_tick cycle; kill pulses exactly 1 cycle.
//  t1_flash = (cd1!=0) & cd1[2] (same for t2); 0 outside PLAY.
//  IDLE/OVER: no hit evaluation, cooldowns cleared, kills held 0.
// TESTING
//  1 Reset, start pulse -> state 01, healths 3/3, winner 00, flashes 0.
//  2 t2=(100,100), b1=(110,110) live, 1 tick -> p2_health 2, b1_kill 1 cycle, t2 immune 30 ticks.
//  3 Same overlap held 30 ticks -> no further damage; tick 31 -> p2_health 1.
//  4 b1=(132,100) vs t2=(100,100) (touching edge) -> no hit; b1=(131,100) -> hit.
//  5 Both healths 1, mutual overlap same tick -> both 0, state 10, winner 11; start -> IDLE.
//  6 Reset asserted mid-PLAY on tick cycle -> IDLE, healths 3/3, no kill pulse emitted.

Source files
------------

// File: rtl/tank_hit_ctrl.sv
// Bullet-versus-tank hit detection, health bookkeeping and round sequencing for a
// two-player tank game. Hits are evaluated once per frame strobe while a round is in play.
module tank_hit_ctrl #(
   parameter int TANK_SIZE       = 32,
   parameter int BULLET_SIZE     = 16,
   parameter int MAX_HEALTH      = 3,
   parameter int HEALTH_W        = 2,
   parameter int COOLDOWN_FRAMES = 30
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                frame_clk,
   input  logic                start,
   input  logic [9:0]          t1_X,
   input  logic [9:0]          t1_Y,
   input  logic [9:0]          t2_X,
   input  logic [9:0]          t2_Y,
   input  logic [9:0]          b1_X,
   input  logic [9:0]          b1_Y,
   input  logic [9:0]          b2_X,
   input  logic [9:0]          b2_Y,
   input  logic                b1_live,
   input  logic                b2_live,
   output logic [HEALTH_W-1:0] p1_health,
   output logic [HEALTH_W-1:0] p2_health,
   output logic                b1_kill,
   output logic                b2_kill,
   output logic                t1_flash,
   output logic                t2_flash,
   output logic [1:0]          game_state,
   output logic [1:0]          winner
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_PLAY = 2'b01,
      S_OVER = 2'b10
   } state_t;

   state_t              r_state;
   logic                r_fc_hist;
   logic                r_tick;
   logic                r_start_hist;
   logic                r_start_pulse;
   logic [5:0]          r_cd1;
   logic [5:0]          r_cd2;
   logic [HEALTH_W-1:0] r_p1;
   logic [HEALTH_W-1:0] r_p2;
   logic                r_k1;
   logic                r_k2;
   logic [1:0]          r_winner;

   logic                w_hit1;
   logic                w_hit2;
   logic [HEALTH_W-1:0] w_p1_after;
   logic [HEALTH_W-1:0] w_p2_after;
   logic [5:0]          w_cd1_after;
   logic [5:0]          w_cd2_after;

   // Widened to 11 bits so box edges near the right/bottom of the screen never wrap.
   function automatic logic overlap(input logic [9:0] bx, input logic [9:0] by,
                                    input logic [9:0] tx, input logic [9:0] ty);
      return ({1'b0, bx} < ({1'b0, tx} + 11'(TANK_SIZE)))   &&
             (({1'b0, bx} + 11'(BULLET_SIZE)) > {1'b0, tx}) &&
             ({1'b0, by} < ({1'b0, ty} + 11'(TANK_SIZE)))   &&
             (({1'b0, by} + 11'(BULLET_SIZE)) > {1'b0, ty});
   endfunction

   assign w_hit2 = b1_live && overlap(b1_X, b1_Y, t2_X, t2_Y) && (r_cd2 == 6'd0);
   assign w_hit1 = b2_live && overlap(b2_X, b2_Y, t1_X, t1_Y) && (r_cd1 == 6'd0);

   assign w_p1_after  = (w_hit1 && r_p1 != '0) ? r_p1 - HEALTH_W'(1) : r_p1;
   assign w_p2_after  = (w_hit2 && r_p2 != '0) ? r_p2 - HEALTH_W'(1) : r_p2;
   assign w_cd1_after = w_hit1 ? 6'(COOLDOWN_FRAMES) : ((r_cd1 != 6'd0) ? r_cd1 - 6'd1 : 6'd0);
   assign w_cd2_after = w_hit2 ? 6'(COOLDOWN_FRAMES) : ((r_cd2 != 6'd0) ? r_cd2 - 6'd1 : 6'd0);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state       <= S_IDLE;
         r_fc_hist     <= 1'b0;
         r_tick        <= 1'b0;
         r_start_hist  <= 1'b0;
         r_start_pulse <= 1'b0;
         r_cd1         <= 6'd0;
         r_cd2         <= 6'd0;
         r_p1          <= HEALTH_W'(MAX_HEALTH);
         r_p2          <= HEALTH_W'(MAX_HEALTH);
         r_k1          <= 1'b0;
         r_k2          <= 1'b0;
         r_winner      <= 2'b00;
      end else begin
         r_fc_hist     <= frame_clk;
         r_tick        <= frame_clk & ~r_fc_hist;
         r_start_hist  <= start;
         r_start_pulse <= start & ~r_start_hist;
         r_k1          <= 1'b0;
         r_k2          <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cd1 <= 6'd0;
               r_cd2 <= 6'd0;
               if (r_start_pulse) begin
                  r_p1     <= HEALTH_W'(MAX_HEALTH);
                  r_p2     <= HEALTH_W'(MAX_HEALTH);
                  r_winner <= 2'b00;
                  r_state  <= S_PLAY;
               end
            end
            S_PLAY: begin
               if (r_tick) begin
                  r_p1  <= w_p1_after;
                  r_p2  <= w_p2_after;
                  r_cd1 <= w_cd1_after;
                  r_cd2 <= w_cd2_after;
                  r_k1  <= w_hit2;
                  r_k2  <= w_hit1;
                  // Winner bits: bit1 set when P1 is out (P2 wins), bit0 when P2 is out.
                  if (w_p1_after == '0 || w_p2_after == '0) begin
                     r_winner <= {w_p1_after == '0, w_p2_after == '0};
                     r_state  <= S_OVER;
                  end
               end
            end
            S_OVER: begin
               r_cd1 <= 6'd0;
               r_cd2 <= 6'd0;
               if (r_start_pulse) begin
                  r_winner <= 2'b00;
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign p1_health  = r_p1;
   assign p2_health  = r_p2;
   assign b1_kill    = r_k1;
   assign b2_kill    = r_k2;
   assign t1_flash   = (r_state == S_PLAY) && (r_cd1 != 6'd0) && r_cd1[2];
   assign t2_flash   = (r_state == S_PLAY) && (r_cd2 != 6'd0) && r_cd2[2];
   assign game_state = r_state;
   assign winner     = r_winner;

endmodule

// File: tb/tb_tank_hit_ctrl.sv
// Directed and randomized checks of tank_hit_ctrl against a frame-level model of the
// game rules (box overlap, health, immunity, round state, winner).
module tb_tank_hit_ctrl;

   logic       Clk = 1'b0;
   logic       Reset, frame_clk, start;
   logic [9:0] t1_X, t1_Y, t2_X, t2_Y, b1_X, b1_Y, b2_X, b2_Y;
   logic       b1_live, b2_live;
   logic [1:0] p1_health, p2_health, game_state, winner;
   logic       b1_kill, b2_kill, t1_flash, t2_flash;

   int n_cmp = 0;
   int n_fail = 0;

   // Model state: st 0 idle / 1 play / 2 over
   int m_st, m_h1, m_h2, m_cd1, m_cd2, m_win, m_k1, m_k2;
   int obs_k1, obs_k2;

   always #10 Clk = ~Clk;

   tank_hit_ctrl dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start),
      .t1_X(t1_X), .t1_Y(t1_Y), .t2_X(t2_X), .t2_Y(t2_Y),
      .b1_X(b1_X), .b1_Y(b1_Y), .b2_X(b2_X), .b2_Y(b2_Y),
      .b1_live(b1_live), .b2_live(b2_live),
      .p1_health(p1_health), .p2_health(p2_health),
      .b1_kill(b1_kill), .b2_kill(b2_kill),
      .t1_flash(t1_flash), .t2_flash(t2_flash),
      .game_state(game_state), .winner(winner)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ov(input int bx, input int by, input int tx, input int ty);
      return (bx < tx + 32 && bx + 16 > tx && by < ty + 32 && by + 16 > ty) ? 1 : 0;
   endfunction

   function automatic int flash_of(input int cd);
      return (m_st == 1 && cd != 0 && ((cd / 4) % 2) == 1) ? 1 : 0;
   endfunction

   task automatic check_all(input string tag);
      $display("%s: state=%0d h1=%0d h2=%0d win=%0d k1=%0d k2=%0d", tag,
               game_state, p1_health, p2_health, winner, obs_k1, obs_k2);
      chk({tag, " state"},  32'(game_state), 32'(m_st));
      chk({tag, " h1"},     32'(p1_health),  32'(m_h1));
      chk({tag, " h2"},     32'(p2_health),  32'(m_h2));
      chk({tag, " winner"}, 32'(winner),     32'(m_win));
      chk({tag, " kill1"},  32'(obs_k1),     32'(m_k1));
      chk({tag, " kill2"},  32'(obs_k2),     32'(m_k2));
      chk({tag, " flash1"}, 32'(t1_flash),   32'(flash_of(m_cd1)));
      chk({tag, " flash2"}, 32'(t2_flash),   32'(flash_of(m_cd2)));
   endtask

   task automatic model_reset();
      m_st = 0; m_h1 = 3; m_h2 = 3; m_cd1 = 0; m_cd2 = 0; m_win = 0; m_k1 = 0; m_k2 = 0;
   endtask

   task automatic count_kills(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge Clk);
         obs_k1 += int'(b1_kill);
         obs_k2 += int'(b2_kill);
      end
   endtask

   task automatic do_tick(input string tag);
      int hit1, hit2;
      obs_k1 = 0; obs_k2 = 0;
      frame_clk = 1'b1;
      count_kills(5);
      frame_clk = 1'b0;
      count_kills(3);
      m_k1 = 0; m_k2 = 0;
      if (m_st == 1) begin
         hit2 = (b1_live && ov(int'(b1_X), int'(b1_Y), int'(t2_X), int'(t2_Y)) && m_cd2 == 0) ? 1 : 0;
         hit1 = (b2_live && ov(int'(b2_X), int'(b2_Y), int'(t1_X), int'(t1_Y)) && m_cd1 == 0) ? 1 : 0;
         m_cd1 = hit1 ? 30 : (m_cd1 > 0 ? m_cd1 - 1 : 0);
         m_cd2 = hit2 ? 30 : (m_cd2 > 0 ? m_cd2 - 1 : 0);
         if (hit1 && m_h1 > 0) m_h1--;
         if (hit2 && m_h2 > 0) m_h2--;
         m_k1 = hit2; m_k2 = hit1;
         if (m_h1 == 0 || m_h2 == 0) begin
            m_st  = 2;
            m_win = (m_h1 == 0 && m_h2 == 0) ? 3 : (m_h2 == 0 ? 1 : 2);
            m_cd1 = 0; m_cd2 = 0;
         end
      end
      check_all(tag);
   endtask

   task automatic do_start(input string tag);
      obs_k1 = 0; obs_k2 = 0;
      start = 1'b1;
      count_kills(5);
      start = 1'b0;
      count_kills(3);
      m_k1 = 0; m_k2 = 0;
      if (m_st == 0) begin
         m_st = 1; m_h1 = 3; m_h2 = 3; m_cd1 = 0; m_cd2 = 0; m_win = 0;
      end else if (m_st == 2) begin
         m_st = 0; m_win = 0;
      end
      check_all(tag);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      model_reset();
   endtask

   task automatic place(input int ax, input int ay, input int bx, input int by,
                        input int c1x, input int c1y, input int l1,
                        input int c2x, input int c2y, input int l2);
      t1_X = 10'(ax);  t1_Y = 10'(ay);  t2_X = 10'(bx);  t2_Y = 10'(by);
      b1_X = 10'(c1x); b1_Y = 10'(c1y); b1_live = 1'(l1);
      b2_X = 10'(c2x); b2_Y = 10'(c2y); b2_live = 1'(l2);
   endtask

   function automatic int near(input int base);
      int v;
      v = base - 20 + int'($urandom_range(0, 56));
      return (v < 0) ? 0 : v;
   endfunction

   initial begin
      Reset = 1'b1; frame_clk = 1'b0; start = 1'b0;
      place(400, 400, 100, 100, 0, 0, 0, 0, 0, 0);
      obs_k1 = 0; obs_k2 = 0;
      repeat (2) @(negedge Clk);
      do_reset();
      check_all("reset");

      do_start("start_to_play");
      chk("play_state_const", 32'(game_state), 32'd1);

      // Single hit, then immunity while the overlap is held
      place(400, 400, 100, 100, 110, 110, 1, 0, 0, 0);
      do_tick("first_hit");
      chk("first_hit_h2_const", 32'(p2_health), 32'd2);
      chk("first_hit_kill_const", 32'(obs_k1), 32'd1);
      for (int i = 0; i < 30; i++) do_tick($sformatf("immune_%0d", i));
      chk("immune_h2_const", 32'(p2_health), 32'd2);
      do_tick("tick31_hit");
      chk("tick31_h2_const", 32'(p2_health), 32'd1);

      // Let immunity expire with no bullet, then the touching-edge boundary
      place(400, 400, 100, 100, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 30; i++) do_tick($sformatf("idle_cd_%0d", i));
      place(400, 400, 100, 100, 132, 100, 1, 0, 0, 0);
      do_tick("edge_touch");
      chk("edge_touch_h2_const", 32'(p2_health), 32'd1);
      place(400, 400, 100, 100, 131, 100, 1, 0, 0, 0);
      do_tick("edge_overlap");
      chk("p1_wins_winner_const", 32'(winner), 32'd1);
      chk("p1_wins_state_const", 32'(game_state), 32'd2);
      do_tick("over_no_eval");
      do_start("over_to_idle");
      do_start("idle_to_play");

      // Mutual hits down to a draw
      for (int r = 0; r < 3; r++) begin
         place(400, 400, 100, 100, 100, 100, 1, 400, 400, 1);
         do_tick($sformatf("mutual_%0d", r));
         place(400, 400, 100, 100, 0, 0, 0, 0, 0, 0);
         if (r < 2) for (int i = 0; i < 30; i++) do_tick($sformatf("mutual_cd_%0d_%0d", r, i));
      end
      chk("draw_winner_const", 32'(winner), 32'd3);
      do_start("draw_to_idle");
      chk("draw_idle_const", 32'(game_state), 32'd0);

      // Reset landing on the tick cycle with an overlap pending
      do_start("play_for_reset");
      place(400, 400, 100, 100, 110, 110, 1, 0, 0, 0);
      obs_k1 = 0; obs_k2 = 0;
      frame_clk = 1'b1;
      @(negedge Clk);
      Reset = 1'b1;
      count_kills(1);
      Reset = 1'b0;
      count_kills(2);
      frame_clk = 1'b0;
      count_kills(3);
      model_reset();
      check_all("reset_on_tick");

      // Randomized rounds
      for (int i = 0; i < 250; i++) begin
         int ax, ay, bx, by;
         ax = int'($urandom_range(20, 900)); ay = int'($urandom_range(20, 900));
         bx = int'($urandom_range(20, 900)); by = int'($urandom_range(20, 900));
         place(ax, ay, bx, by, near(bx), near(by), int'($urandom_range(0, 1)),
               near(ax), near(ay), int'($urandom_range(0, 1)));
         if ($urandom_range(0, 7) == 0 || m_st != 1) do_start($sformatf("rnd_start_%0d", i));
         else do_tick($sformatf("rnd_tick_%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
